// File: rtl/layer_seq_pkg.sv
// Shared encodings for the layer command sequencer: op codes, descriptor
// field positions and FSM state constants.
package layer_seq_pkg;

    localparam logic [1:0] OP_RUN    = 2'd0;
    localparam logic [1:0] OP_POOL   = 2'd1;
    localparam logic [1:0] OP_WWRITE = 2'd2;
    localparam logic [1:0] OP_BWRITE = 2'd3;

    localparam int F_OP_LSB    = 0;
    localparam int F_BACKPROP  = 2;
    localparam int F_DELTAW    = 3;
    localparam int F_ENBIAS    = 4;
    localparam int F_DWCONV    = 5;
    localparam int F_IRQ_EN    = 6;
    localparam int F_BEATS_LSB = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    // Mode vector order is {bwrite, wwrite, pool, run}.
    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        return 4'b0001 << op;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Descriptor FIFO: synchronous write, head always visible on rdata,
// occupancy count and a synchronous flush that also discards a same-cycle push.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH)) && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/layer_seq.sv
// Layer command sequencer: walks queued descriptors, raising one mode output
// per layer and dropping it for a gap cycle so downstream controllers reset.
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int BW    = 16
) (
    input  logic                       AXIS_ACLK,
    input  logic                       AXIS_ARESETN,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [31:0]                cmd_data,
    input  logic                       src_beat,
    input  logic                       layer_done,
    input  logic                       out_idle,
    input  logic                       abort,
    input  logic                       err_clr,
    output logic                       run,
    output logic                       pool,
    output logic                       wwrite,
    output logic                       bwrite,
    output logic                       backprop,
    output logic                       deltaw,
    output logic                       enbias,
    output logic                       dwconv,
    output logic                       busy,
    output logic                       irq,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] cmd_count,
    output logic [2:0]                 state_dbg
);

    localparam int CW = $clog2(DEPTH+1);

    logic [2:0]    state, state_next;
    logic [31:0]   desc_q, desc_next, fifo_rdata;
    logic [BW-1:0] beat_cnt, beat_cnt_next, beats;
    logic          done_seen;
    logic [3:0]    mode_q, flags_q;
    logic          irq_q, err_q;
    logic          push, pop, stray_beat, in_layer_next;
    logic          unused_rsv;

    // A descriptor transfers on cmd_valid && cmd_ready; cmd_valid must hold
    // with stable cmd_data until that cycle, cmd_ready depends only on occupancy.
    assign cmd_ready = (cmd_count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready && !abort;
    assign pop       = (state == ST_IDLE) && (cmd_count != '0) && !abort;

    seq_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk   (AXIS_ACLK),
        .rst_n (AXIS_ARESETN),
        .flush (abort),
        .push  (push),
        .pop   (pop),
        .wdata (cmd_data),
        .rdata (fifo_rdata),
        .count (cmd_count)
    );

    assign beats      = desc_q[F_BEATS_LSB +: BW];
    assign unused_rsv = ^{desc_q[31:24], desc_q[7]};
    assign stray_beat = src_beat &&
                        (((state != ST_ACTIVE) && (state != ST_DRAIN)) || (beat_cnt == beats));

    always_comb begin
        state_next    = state;
        desc_next     = desc_q;
        beat_cnt_next = beat_cnt;
        if ((state == ST_ACTIVE) && src_beat && (beat_cnt != beats))
            beat_cnt_next = beat_cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    state_next = ST_SETUP;
                    desc_next  = fifo_rdata;
                end
            end
            ST_SETUP:  state_next = ST_ACTIVE;
            // Writes finish on beat count alone; compute ops also need layer_done.
            ST_ACTIVE: begin
                if ((beat_cnt_next == beats) &&
                    (desc_q[F_OP_LSB+1] || done_seen || layer_done))
                    state_next = ST_DRAIN;
            end
            ST_DRAIN:  if (out_idle) state_next = ST_GAP;
            ST_GAP:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (abort) state_next = ST_IDLE;
    end

    assign in_layer_next = (state_next == ST_SETUP) || (state_next == ST_ACTIVE) ||
                           (state_next == ST_DRAIN);

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state     <= ST_IDLE;
            desc_q    <= '0;
            beat_cnt  <= '0;
            done_seen <= 1'b0;
            mode_q    <= '0;
            flags_q   <= '0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            desc_q    <= desc_next;
            beat_cnt  <= (state == ST_SETUP) ? '0 : beat_cnt_next;
            if (state == ST_SETUP)                      done_seen <= 1'b0;
            else if ((state == ST_ACTIVE) && layer_done) done_seen <= 1'b1;
            mode_q    <= ((state_next == ST_ACTIVE) || (state_next == ST_DRAIN)) ?
                         op_onehot(desc_next[F_OP_LSB +: 2]) : 4'b0000;
            flags_q   <= in_layer_next ? desc_next[F_DWCONV:F_BACKPROP] : 4'b0000;
            irq_q     <= (state_next == ST_GAP) && desc_next[F_IRQ_EN];
            if (stray_beat)   err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    assign {bwrite, wwrite, pool, run}          = mode_q;
    assign {dwconv, enbias, deltaw, backprop}   = flags_q;
    assign irq       = irq_q;
    assign err       = err_q;
    assign busy      = (state != ST_IDLE) || (cmd_count != '0);
    assign state_dbg = state;

endmodule
